// File: rtl/seq_divider.sv
// Iterative restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Define SEQ_DIV_EARLY_OUT_EN to finish D==0 and N<D operations without the CALC phase.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dz,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  d_q, d_d;
  logic [8:0]  r_q, r_d;
  logic [15:0] q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  logic [8:0]  r_shift, r_step;
  logic        q_bit;
  logic [15:0] q_step;

  // One restoring step: r stays below D, so the shifted value fits in 9 bits.
  always_comb begin
    r_shift = {r_q[7:0], n_q[15]};
    q_bit   = (r_shift >= {1'b0, d_q});
    r_step  = q_bit ? (r_shift - {1'b0, d_q}) : r_shift;
    q_step  = {q_q[14:0], q_bit};
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          n_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SEQ_DIV_EARLY_OUT_EN
          if (divisor == 8'h00) begin
            state_d = DONE;
            quot_d  = 16'hFFFF;
            rem_d   = 8'hFF;
            dz_d    = 1'b1;
            ovf_d   = 1'b1;
          end else if (dividend < {8'h00, divisor}) begin
            state_d = DONE;
            quot_d  = '0;
            rem_d   = dividend[7:0];
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
          end
`endif
        end
      end

      CALC: begin
        n_d   = {n_q[14:0], 1'b0};
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          if (d_q == 8'h00) begin
            quot_d = 16'hFFFF;
            rem_d  = 8'hFF;
            dz_d   = 1'b1;
            ovf_d  = 1'b1;
          end else begin
            quot_d = q_step;
            rem_d  = r_step[7:0];
            dz_d   = 1'b0;
            ovf_d  = |q_step[15:8];
          end
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: working datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    n_q <= n_d;
    d_q <= d_d;
    r_q <= r_d;
    q_q <= q_d;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized operations
// compared against an arithmetic (/, %) reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dz;
  logic        ovf;

  int n_checks = 0;
  int n_passed = 0;

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain division; latency counted in edges after the accept edge.
  function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
    exp_t e;
    int   qi;
    if (d == 0) begin
      e.q = 16'hFFFF; e.r = 8'hFF; e.dz = 1'b1; e.ovf = 1'b1;
    end else begin
      qi    = int'(n) / int'(d);
      e.q   = qi[15:0];
      e.r   = 8'(int'(n) % int'(d));
      e.dz  = 1'b0;
      e.ovf = (qi > 255);
    end
`ifdef SEQ_DIV_EARLY_OUT_EN
    e.lat = (d == 0 || int'(n) < int'(d)) ? 0 : 16;
`else
    e.lat = 16;
`endif
    return e;
  endfunction

  task automatic run_op(input logic [15:0] n, input logic [7:0] d, input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    e = model(n, d);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; dividend = n; divisor = d;
    tick();
    in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin seen = 1'b1; break; end
      tick();
      lat++;
    end
    check("done_reached", seen, 1);
    if (!seen) return;
    check("latency", lat, e.lat);
    check("in_ready_done", in_ready, 0);
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("dz", dz, e.dz);
    check("ovf", ovf, e.ovf);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_quotient", quotient, e.q);
      check("hold_remainder", remainder, e.r);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    check("idle_quotient", quotient, e.q);
    check("idle_remainder", remainder, e.r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;

    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1);

    run_op(16'd35, 8'd6, 0);
    run_op(16'hFFFF, 8'd1, 0);
    run_op(16'd65025, 8'd255, 0);
    run_op(16'h1234, 8'd0, 0);
    run_op(16'd7, 8'd9, 0);
    run_op(16'd1000, 8'd3, 5);

    // Reset in the middle of CALC aborts the operation and clears the outputs.
    in_valid = 1'b1; dividend = 16'd5000; divisor = 8'd13;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    check("abort_ready_in_rst", in_ready, 0);
    check("abort_valid", out_valid, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dz", dz, 0);
    check("abort_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check("abort_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_result", out_valid, 0);
    run_op(16'd100, 8'd7, 0);

    // in_valid during reset must not be accepted.
    rst_n = 1'b0; in_valid = 1'b1; dividend = 16'd50; divisor = 8'd3;
    #1;
    check("rst_valid_ready", in_ready, 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("rst_valid_not_taken", out_valid, 0);
    check("rst_valid_idle", in_ready, 1);

    for (int k = 0; k < 40; k++) begin
      rn = 16'($urandom);
      rd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 8'd0;
      if ($urandom_range(0, 5) == 0) rn = 16'($urandom_range(0, 300));
      run_op(rn, rd, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
